// File: rtl/ram_wr_control_pkg.sv
// Shared definitions for the frame RAM write/read controllers:
// default geometry and the write-side FSM state encoding.
package ram_wr_control_pkg;

    localparam int DW_DEFAULT      = 16;
    localparam int AW_DEFAULT      = 4;
    localparam int DEPTH_DEFAULT   = 16;
    localparam int RD_HOLD_DEFAULT = 17;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_WAIT_RD = 3'd4
    } wr_state_t;

endpackage

// File: rtl/ram_wr_control.sv
// Writes one fixed-length frame into a dual-port RAM, flags malformed frames,
// and hands a complete frame to the downstream reader with a one-cycle rd_sop.
module ram_wr_control
    import ram_wr_control_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int AW      = AW_DEFAULT,
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int RD_HOLD = RD_HOLD_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sop,
    input  logic          in_eop,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          ram_wr_en,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          rd_sop,
    output logic          frame_err,
    output logic          busy
);

    localparam int            HW        = $clog2(RD_HOLD + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    wr_state_t     state_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [HW-1:0] hold_reg;
    logic          ram_wr_en_reg;
    logic [AW-1:0] ram_waddr_reg;
    logic [DW-1:0] ram_wdata_reg;
    logic          rd_sop_reg;
    logic          frame_err_reg;
    logic          accept;

    assign in_ready  = (state_reg == ST_IDLE) || (state_reg == ST_WRITE) ||
                       (state_reg == ST_DRAIN);
    assign busy      = (state_reg != ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign ram_wr_en = ram_wr_en_reg;
    assign ram_waddr = ram_waddr_reg;
    assign ram_wdata = ram_wdata_reg;
    assign rd_sop    = rd_sop_reg;
    assign frame_err = frame_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            wr_ptr_reg    <= '0;
            hold_reg      <= '0;
            ram_wr_en_reg <= 1'b0;
            ram_waddr_reg <= '0;
            ram_wdata_reg <= '0;
            rd_sop_reg    <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            ram_wr_en_reg <= 1'b0;
            rd_sop_reg    <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept && in_sop) begin
                        ram_wr_en_reg <= 1'b1;
                        ram_waddr_reg <= '0;
                        ram_wdata_reg <= in_data;
                        if (in_eop) begin
                            frame_err_reg <= 1'b1;
                        end else begin
                            wr_ptr_reg <= AW'(1);
                            state_reg  <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (accept) begin
                        ram_wr_en_reg <= 1'b1;
                        ram_wdata_reg <= in_data;
                        if (in_sop && !in_eop) begin
                            // Restart: the new sop beat becomes word 0 of a fresh frame
                            ram_waddr_reg <= '0;
                            wr_ptr_reg    <= AW'(1);
                            frame_err_reg <= 1'b1;
                        end else begin
                            ram_waddr_reg <= wr_ptr_reg;
                            if (in_eop) begin
                                wr_ptr_reg <= '0;
                                if (wr_ptr_reg == LAST_ADDR && !in_sop) begin
                                    state_reg <= ST_FLUSH;
                                end else begin
                                    frame_err_reg <= 1'b1;
                                    state_reg     <= ST_IDLE;
                                end
                            end else if (wr_ptr_reg == LAST_ADDR) begin
                                state_reg <= ST_DRAIN;
                            end else begin
                                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept) begin
                        if (in_sop && !in_eop) begin
                            ram_wr_en_reg <= 1'b1;
                            ram_waddr_reg <= '0;
                            ram_wdata_reg <= in_data;
                            wr_ptr_reg    <= AW'(1);
                            frame_err_reg <= 1'b1;
                            state_reg     <= ST_WRITE;
                        end else if (in_eop) begin
                            wr_ptr_reg    <= '0;
                            frame_err_reg <= 1'b1;
                            state_reg     <= ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Last word is on the RAM port this cycle; reader may start next cycle
                    rd_sop_reg <= 1'b1;
                    hold_reg   <= HW'(RD_HOLD);
                    state_reg  <= ST_WAIT_RD;
                end
                ST_WAIT_RD: begin
                    if (hold_reg <= HW'(1)) begin
                        hold_reg  <= '0;
                        state_reg <= ST_IDLE;
                    end else begin
                        hold_reg <= hold_reg - HW'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_wr_control.sv
// Bench for ram_wr_control: directed frame scenarios plus randomized frames,
// checked every cycle against a frame-level behavioural model.
module tb_ram_wr_control;

    localparam int DEPTH   = 16;
    localparam int RD_HOLD = 17;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        ram_wr_en;
    logic [3:0]  ram_waddr;
    logic [15:0] ram_wdata;
    logic        rd_sop;
    logic        frame_err;
    logic        busy;

    ram_wr_control dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ram_wr_en (ram_wr_en),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .rd_sop    (rd_sop),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: tracks beats received, whether excess beats are being
    // dropped, and how many cycles the block stays unavailable after a good frame.
    bit          m_in_frame = 0;
    bit          m_drop = 0;
    int          m_beats = 0;
    int          m_block = 0;
    logic        e_wr = 0;
    logic [3:0]  e_addr = '0;
    logic [15:0] e_data = '0;
    logic        e_sop = 0;
    logic        e_err = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in_frame = 0; m_drop = 0; m_beats = 0; m_block = 0;
            e_wr = 0; e_addr = '0; e_data = '0; e_sop = 0; e_err = 0;
        end else begin
            e_wr = 0; e_sop = 0; e_err = 0;
            if (m_block > 0) begin
                m_block--;
                if (m_block == RD_HOLD) e_sop = 1;
            end else if (in_valid) begin
                if (in_sop && in_eop) begin
                    if (!m_drop) begin
                        e_wr = 1;
                        e_addr = m_in_frame ? 4'(m_beats) : 4'd0;
                        e_data = in_data;
                    end
                    e_err = 1;
                    m_in_frame = 0; m_drop = 0;
                end else if (in_sop) begin
                    e_err = m_in_frame || m_drop;
                    e_wr = 1; e_addr = 4'd0; e_data = in_data;
                    m_beats = 1; m_in_frame = 1; m_drop = 0;
                end else if (m_in_frame) begin
                    e_wr = 1; e_addr = 4'(m_beats); e_data = in_data;
                    m_beats++;
                    if (in_eop) begin
                        m_in_frame = 0;
                        if (m_beats == DEPTH) m_block = RD_HOLD + 1;
                        else e_err = 1;
                    end else if (m_beats == DEPTH) begin
                        m_in_frame = 0; m_drop = 1;
                    end
                end else if (m_drop && in_eop) begin
                    e_err = 1; m_drop = 0;
                end
            end
        end
    end

    // Observed activity, used by directed scenarios
    logic [15:0] dut_ram [16];
    int          sop_cnt = 0;
    int          err_cnt = 0;
    int          wr_cnt = 0;
    int          ready_low = 0;
    time         sop_t = 0;
    time         last_edge_t = 0;

    always @(negedge clk) begin
        chk("wr_en", 32'(ram_wr_en), 32'(e_wr));
        chk("waddr", 32'(ram_waddr), 32'(e_addr));
        chk("wdata", 32'(ram_wdata), 32'(e_data));
        chk("rd_sop", 32'(rd_sop), 32'(e_sop));
        chk("frame_err", 32'(frame_err), 32'(e_err));
        chk("busy", 32'(busy), 32'(m_in_frame || m_drop || m_block > 0));
        chk("in_ready", 32'(in_ready), 32'(m_block == 0));
        if (ram_wr_en === 1'b1) begin
            dut_ram[ram_waddr] = ram_wdata;
            wr_cnt++;
        end
        if (rd_sop === 1'b1) begin
            sop_cnt++;
            sop_t = $time;
        end
        if (frame_err === 1'b1) err_cnt++;
        if (in_ready === 1'b0) ready_low++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic raw(input logic v, input logic s, input logic e, input logic [15:0] d);
        in_valid = v; in_sop = s; in_eop = e; in_data = d;
        @(posedge clk);
        last_edge_t = $time;
        #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    // Presents a beat once the block is ready, so directed frames are never lost
    task automatic drive(input logic s, input logic e, input logic [15:0] d);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            idle(1);
            guard++;
        end
        if (guard >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL ready_timeout: in_ready stayed %b for 100 cycles at %0t", in_ready, $time);
        end
        raw(1'b1, s, e, d);
    endtask

    task automatic send_frame(input int n, input logic [15:0] base, input int eop_at, input bit bubbles);
        for (int i = 1; i <= n; i++) begin
            if (bubbles) raw(1'b0, 1'b0, 1'b0, 16'hFFFF);
            drive(i == 1, i == eop_at, base + 16'(i - 1));
        end
    endtask

    task automatic clear_stats();
        sop_cnt = 0; err_cnt = 0; wr_cnt = 0; ready_low = 0;
        for (int i = 0; i < 16; i++) dut_ram[i] = 16'hDEAD;
    endtask

    task automatic check_ram(input string name, input logic [15:0] base);
        for (int i = 0; i < 16; i++) chk(name, 32'(dut_ram[i]), 32'(base + 16'(i)));
    endtask

    task automatic reset_pulse(input int cycles);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_waddr", 32'(ram_waddr), 32'd0);
        chk("rst_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_rd_sop", 32'(rd_sop), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        idle(cycles);
        rst_n = 1'b1;
        chk("rst_release_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2;
        reset_pulse(3);
        idle(1);

        // Good frame, back-to-back beats
        clear_stats();
        send_frame(16, 16'h1000, 16, 0);
        idle(25);
        $display("good frame: rd_sop=%0d frame_err=%0d ready_low=%0d", sop_cnt, err_cnt, ready_low);
        check_ram("t1_ram", 16'h1000);
        chk("t1_rd_sop_count", 32'(sop_cnt), 32'd1);
        chk("t1_rd_sop_delay", 32'(sop_t - last_edge_t), 32'd15);
        chk("t1_ready_low", 32'(ready_low), 32'd18);
        chk("t1_frame_err", 32'(err_cnt), 32'd0);

        // Same frame with bubbles
        clear_stats();
        send_frame(16, 16'h1000, 16, 1);
        idle(25);
        $display("bubbled frame: rd_sop=%0d frame_err=%0d", sop_cnt, err_cnt);
        check_ram("t2_ram", 16'h1000);
        chk("t2_rd_sop_count", 32'(sop_cnt), 32'd1);
        chk("t2_rd_sop_delay", 32'(sop_t - last_edge_t), 32'd15);

        // Short frame
        clear_stats();
        send_frame(5, 16'h5000, 5, 0);
        chk("t3_busy_after", 32'(busy), 32'd0);
        idle(3);
        $display("short frame: rd_sop=%0d frame_err=%0d writes=%0d", sop_cnt, err_cnt, wr_cnt);
        chk("t3_frame_err", 32'(err_cnt), 32'd1);
        chk("t3_rd_sop", 32'(sop_cnt), 32'd0);
        chk("t3_writes", 32'(wr_cnt), 32'd5);

        // Over-length frame
        clear_stats();
        send_frame(20, 16'h2000, 20, 0);
        idle(3);
        $display("long frame: rd_sop=%0d frame_err=%0d writes=%0d", sop_cnt, err_cnt, wr_cnt);
        check_ram("t4_ram", 16'h2000);
        chk("t4_frame_err", 32'(err_cnt), 32'd1);
        chk("t4_rd_sop", 32'(sop_cnt), 32'd0);
        chk("t4_writes", 32'(wr_cnt), 32'd16);

        // Restart on beat 8
        clear_stats();
        send_frame(7, 16'h3000, 0, 0);
        send_frame(16, 16'h4000, 16, 0);
        idle(25);
        $display("restarted frame: rd_sop=%0d frame_err=%0d", sop_cnt, err_cnt);
        check_ram("t5_ram", 16'h4000);
        chk("t5_frame_err", 32'(err_cnt), 32'd1);
        chk("t5_rd_sop", 32'(sop_cnt), 32'd1);

        // Reset in WAIT_RD and mid-frame, then a normal frame
        clear_stats();
        send_frame(16, 16'h6000, 16, 0);
        idle(5);
        reset_pulse(2);
        chk("t6_rd_sop_before_reset", 32'(sop_cnt), 32'd1);
        send_frame(9, 16'h7000, 0, 0);
        reset_pulse(2);
        clear_stats();
        send_frame(16, 16'h8000, 16, 0);
        idle(25);
        $display("post-reset frame: rd_sop=%0d frame_err=%0d", sop_cnt, err_cnt);
        check_ram("t6_ram", 16'h8000);
        chk("t6_rd_sop", 32'(sop_cnt), 32'd1);
        chk("t6_frame_err", 32'(err_cnt), 32'd0);

        // Randomized frames, beats offered regardless of in_ready
        for (int f = 0; f < 150; f++) begin
            int len;
            int pick;
            pick = $urandom_range(0, 5);
            len = (pick == 0) ? $urandom_range(1, 15) : (pick == 1) ? $urandom_range(17, 22) : 16;
            if ($urandom_range(0, 29) == 0) reset_pulse($urandom_range(1, 3));
            for (int i = 1; i <= len; i++) begin
                logic s;
                logic e;
                while ($urandom_range(0, 9) < 3) raw(1'b0, 1'(($urandom_range(0, 1))), 1'b0, 16'($urandom));
                s = (i == 1) || ($urandom_range(0, 39) == 0);
                e = (i == len) || ($urandom_range(0, 59) == 0);
                raw(1'b1, s, e, 16'($urandom));
            end
            if ($urandom_range(0, 3) == 0) raw(1'b1, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
            if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 20));
        end
        idle(25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_wr_control.md
RAM_WR_CONTROL -- requirements
Module: ram_wr_control

Interface
REQ-001 Parameters (name, default, meaning): DW, 16, data width; AW, 4, RAM address width; DEPTH, 16, words per frame; RD_HOLD, 17, cycles the downstream reader needs after rd_sop.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream beat valid.
REQ-005 in_sop  input  1  first beat of frame, qualified by in_valid.
REQ-006 in_eop  input  1  last beat of frame, qualified by in_valid.
REQ-007 in_data  input  DW  beat payload.
REQ-008 in_ready  output  1  block accepts a beat this cycle; a beat transfers when in_valid and in_ready are both 1.
REQ-009 ram_wr_en  output  1  dual-port RAM write enable.
REQ-010 ram_waddr  output  AW  RAM write address.
REQ-011 ram_wdata  output  DW  RAM write data.
REQ-012 rd_sop  output  1  one-cycle pulse starting the downstream read controller.
REQ-013 frame_err  output  1  one-cycle pulse on a malformed frame.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, WRITE, DRAIN, FLUSH, WAIT_RD.
REQ-016 in_ready = 1 in IDLE, WRITE, DRAIN; 0 in FLUSH, WAIT_RD.
REQ-017 IDLE: accepted beat without in_sop is discarded; accepted beat with in_sop is written at address 0 -> WRITE (or error per REQ-022).
REQ-018 Write latency: beat accepted in cycle n appears on ram_wr_en=1/ram_waddr/ram_wdata in cycle n+1, all registered; ram_wr_en = 0 in all other cycles.
REQ-019 Write address counter starts at 0 per frame, increments by 1 per accepted beat, width AW; no beat is written beyond address DEPTH-1.
REQ-020 Good frame: exactly DEPTH beats, in_eop on beat DEPTH only; after beat DEPTH -> FLUSH for one cycle (the cycle the last write is on the RAM port), then rd_sop=1 for one cycle while entering WAIT_RD, i.e. rd_sop in cycle n+2 after the last beat is accepted in cycle n.
REQ-021 WAIT_RD: counter loaded with RD_HOLD on the rd_sop cycle, decrements each cycle; -> IDLE when it reaches 0; no RAM write occurs during WAIT_RD.
REQ-022 Early eop (in_eop on beat k < DEPTH, including sop and eop on the same beat): beat k is written; frame_err pulses in cycle n+1; -> IDLE; no rd_sop.
REQ-023 Over-length (beat DEPTH without in_eop): beat DEPTH is written; -> DRAIN; DRAIN discards beats until an accepted in_eop, then frame_err pulses in the next cycle and -> IDLE; no rd_sop.
REQ-024 in_sop during WRITE or DRAIN: frame_err pulses in the next cycle; the beat is written at address 0; address counter restarts; state -> WRITE.
REQ-025 in_sop and in_eop on the same beat is classified per REQ-022 and never restarts a frame.
REQ-026 Cycles with in_valid=0 insert bubbles: no write, no counter change, no state change.

Reset
REQ-027 Asserting rst_n=0 at any time, including mid-frame or in WAIT_RD, forces IDLE and address counter=0, hold counter=0, ram_wr_en=0, ram_waddr=0, ram_wdata=0, rd_sop=0, frame_err=0, busy=0; in_ready=1 from the first cycle after release.
REQ-028 RAM contents are not cleared by reset; a partially written frame is abandoned and never signalled.

Structure
REQ-029 FSM state encoding and the DW/AW/DEPTH/RD_HOLD defaults go in the shared lab package, which the read controller also uses.
REQ-030 Single flat module; no sub-modules.

Verification
REQ-031 16 consecutive beats with data 0x1000..0x100F, sop on beat 1, eop on beat 16 -> RAM addresses 0..15 hold 0x1000..0x100F; rd_sop pulses exactly once, 2 cycles after beat 16; in_ready=0 for 18 cycles.
REQ-032 Same frame with in_valid dropped every other cycle -> identical RAM contents and one rd_sop, 2 cycles after the last beat.
REQ-033 5-beat frame with eop on beat 5 -> frame_err pulses once, no rd_sop, busy=0 on the next cycle.
REQ-034 20 beats with eop on beat 20 -> addresses 0..15 written, beats 17..20 discarded, frame_err once, no rd_sop.
REQ-035 sop re-asserted on beat 8, then 16 further beats ending in eop -> one frame_err, then one rd_sop; RAM holds the restarted frame.
REQ-036 rst_n pulsed low in WAIT_RD and again at beat 10 -> all outputs at reset values, in_ready=1 after release; the next good frame completes normally.
